// File: rtl/pc_mar_datapath.sv
// PC / MAR / MDR datapath for the sequencer's active-low control strobes.
// Also runs the single-outstanding memory read that each accepted MAR load starts.
module pc_mar_datapath #(
  parameter int ADDR_WIDTH       = 16,
  parameter int DATA_WIDTH       = 16,
  parameter int PC_SELECT_SIZE   = 3,
  parameter int ADDR_SELECT_SIZE = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 16'hFFFE
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        pc_rst_ni,
  input  logic                        pc_ld_ni,
  input  logic [PC_SELECT_SIZE-1:0]   pc_src_i,
  input  logic                        mar_rst_ni,
  input  logic                        mar_ld_ni,
  input  logic [ADDR_SELECT_SIZE-1:0] addr_src_i,
  input  logic [ADDR_WIDTH-1:0]       branch_addr_i,
  input  logic [ADDR_WIDTH-1:0]       alu_result_i,
  input  logic [ADDR_WIDTH-1:0]       data_addr_i,
  output logic                        mem_rd_o,
  output logic [ADDR_WIDTH-1:0]       mem_addr_o,
  input  logic                        mem_ack_i,
  input  logic [DATA_WIDTH-1:0]       mem_data_i,
  output logic [ADDR_WIDTH-1:0]       pc_o,
  output logic [DATA_WIDTH-1:0]       mdr_o,
  output logic                        mdr_valid_o,
  output logic                        busy_o,
  output logic                        overrun_o
);

  // state | meaning
  // IDLE  | no read outstanding
  // REQ   | read issued, waiting for mem_ack_i
  // DONE  | MDR just updated, mdr_valid_o high
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] mar_q;
  logic [DATA_WIDTH-1:0] mdr_q;
  logic [ADDR_WIDTH-1:0] pc_mux;
  logic [ADDR_WIDTH-1:0] addr_mux;

  always_comb begin
    pc_mux = pc_q;
    case (pc_src_i)
      3'b000:  pc_mux = pc_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      3'b001:  pc_mux = branch_addr_i;
      3'b010:  pc_mux = RESET_VECTOR;
      3'b011:  pc_mux = alu_result_i;
      default: pc_mux = pc_q;
    endcase
  end

  // Built from the pre-edge PC so a same-edge PC load does not leak into MAR.
  always_comb begin
    addr_mux = '0;
    case (addr_src_i)
      2'b00:   addr_mux = pc_q;
      2'b01:   addr_mux = alu_result_i;
      2'b10:   addr_mux = data_addr_i;
      default: addr_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_q        <= '0;
      mar_q       <= '0;
      mdr_q       <= '0;
      state_q     <= IDLE;
      mem_rd_o    <= 1'b0;
      busy_o      <= 1'b0;
      mdr_valid_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      if (!pc_rst_ni)
        pc_q <= '0;
      else if (!pc_ld_ni)
        pc_q <= pc_mux;

      mdr_valid_o <= 1'b0;
      if (!mar_rst_ni) begin
        mar_q    <= '0;
        state_q  <= IDLE;
        mem_rd_o <= 1'b0;
        busy_o   <= 1'b0;
      end else begin
        case (state_q)
          IDLE, DONE: begin
            if (!mar_ld_ni) begin
              mar_q    <= addr_mux;
              state_q  <= REQ;
              mem_rd_o <= 1'b1;
              busy_o   <= 1'b1;
            end else begin
              state_q  <= IDLE;
            end
          end
          REQ: begin
            if (!mar_ld_ni)
              overrun_o <= 1'b1;
            if (mem_ack_i) begin
              mdr_q       <= mem_data_i;
              state_q     <= DONE;
              mem_rd_o    <= 1'b0;
              busy_o      <= 1'b0;
              mdr_valid_o <= 1'b1;
            end
          end
          default: begin
            state_q  <= IDLE;
            mem_rd_o <= 1'b0;
            busy_o   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pc_o       = pc_q;
  assign mem_addr_o = mar_q;
  assign mdr_o      = mdr_q;

endmodule

// File: tb/tb_pc_mar_datapath.sv
// Self-checking bench for pc_mar_datapath: directed scenarios plus random strobes
// checked every cycle against a transaction-level reference model.
module tb_pc_mar_datapath;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        pc_rst_ni, pc_ld_ni, mar_rst_ni, mar_ld_ni;
  logic [2:0]  pc_src_i;
  logic [1:0]  addr_src_i;
  logic [15:0] branch_addr_i, alu_result_i, data_addr_i;
  logic        mem_rd_o, mem_ack_i;
  logic [15:0] mem_addr_o, mem_data_i, pc_o, mdr_o;
  logic        mdr_valid_o, busy_o, overrun_o;

  int n_vec = 0;
  int n_err = 0;

  // reference model: an "outstanding read" flag instead of a state machine
  logic [15:0] m_pc, m_mar, m_mdr;
  logic        m_busy, m_valid, m_ovr;

  pc_mar_datapath dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .pc_rst_ni(pc_rst_ni), .pc_ld_ni(pc_ld_ni), .pc_src_i(pc_src_i),
    .mar_rst_ni(mar_rst_ni), .mar_ld_ni(mar_ld_ni), .addr_src_i(addr_src_i),
    .branch_addr_i(branch_addr_i), .alu_result_i(alu_result_i), .data_addr_i(data_addr_i),
    .mem_rd_o(mem_rd_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .pc_o(pc_o), .mdr_o(mdr_o), .mdr_valid_o(mdr_valid_o), .busy_o(busy_o), .overrun_o(overrun_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    reset_i    = 1'b0;
    pc_rst_ni  = 1'b1;
    pc_ld_ni   = 1'b1;
    mar_rst_ni = 1'b1;
    mar_ld_ni  = 1'b1;
    mem_ack_i  = 1'b0;
  endtask

  task automatic model_edge();
    logic [15:0] addr;
    logic        nxt_valid;
    if (reset_i) begin
      m_pc = 0; m_mar = 0; m_mdr = 0; m_busy = 0; m_valid = 0; m_ovr = 0;
      return;
    end
    case (addr_src_i)
      2'd0: addr = m_pc;
      2'd1: addr = alu_result_i;
      2'd2: addr = data_addr_i;
      default: addr = 16'h0000;
    endcase
    if (!pc_rst_ni) m_pc = 0;
    else if (!pc_ld_ni) begin
      if (pc_src_i == 0)      m_pc = 16'((32'(m_pc) + 1) % 65536);
      else if (pc_src_i == 1) m_pc = branch_addr_i;
      else if (pc_src_i == 2) m_pc = 16'hFFFE;
      else if (pc_src_i == 3) m_pc = alu_result_i;
    end
    nxt_valid = 0;
    if (!mar_rst_ni) begin
      m_mar = 0; m_busy = 0;
    end else if (m_busy) begin
      if (!mar_ld_ni) m_ovr = 1;
      if (mem_ack_i) begin m_mdr = mem_data_i; m_busy = 0; nxt_valid = 1; end
    end else if (!mar_ld_ni) begin
      m_mar = addr; m_busy = 1;
    end
    m_valid = nxt_valid;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk_i);
    #1;
    check("pc",   32'(pc_o),        32'(m_pc));
    check("mar",  32'(mem_addr_o),  32'(m_mar));
    check("mdr",  32'(mdr_o),       32'(m_mdr));
    check("rd",   32'(mem_rd_o),    32'(m_busy));
    check("busy", 32'(busy_o),      32'(m_busy));
    check("vld",  32'(mdr_valid_o), 32'(m_valid));
    check("ovr",  32'(overrun_o),   32'(m_ovr));
  endtask

  task automatic do_reset();
    idle_inputs(); reset_i = 1'b1; step(); reset_i = 1'b0;
  endtask

  initial begin
    int cnt;
    logic [15:0] mdr_keep;
    idle_inputs();
    pc_src_i = 0; addr_src_i = 0;
    branch_addr_i = 0; alu_result_i = 0; data_addr_i = 0; mem_data_i = 0;
    m_pc = 0; m_mar = 0; m_mdr = 0; m_busy = 0; m_valid = 0; m_ovr = 0;

    // reset vector sequence
    do_reset();
    check("rst_pc", 32'(pc_o), 32'h0);
    check("rst_rd", 32'(mem_rd_o), 32'h0);
    pc_rst_ni = 0; mar_rst_ni = 0; step(); idle_inputs();
    pc_ld_ni = 0; pc_src_i = 3'b010; step(); idle_inputs();
    check("pc_vec", 32'(pc_o), 32'hFFFE);
    mar_ld_ni = 0; addr_src_i = 2'b00; step(); idle_inputs();
    check("mar_vec", 32'(mem_addr_o), 32'hFFFE);
    check("rd_vec", 32'(mem_rd_o), 32'h1);

    // increment wrap
    do_reset();
    pc_ld_ni = 0; pc_src_i = 3'b001; branch_addr_i = 16'hFFFF; step();
    pc_src_i = 3'b000; step(); idle_inputs();
    check("pc_wrap", 32'(pc_o), 32'h0000);

    // read with three wait states
    mar_ld_ni = 0; addr_src_i = 2'b01; alu_result_i = 16'h1234; step(); idle_inputs();
    check("mar_1234", 32'(mem_addr_o), 32'h1234);
    cnt = int'(busy_o);
    for (int i = 0; i < 3; i++) begin step(); cnt += int'(busy_o); end
    mem_ack_i = 1; mem_data_i = 16'hBEEF; step(); idle_inputs();
    cnt += int'(busy_o);
    check("busy_cycles", 32'(cnt), 32'd4);
    check("mdr_beef", 32'(mdr_o), 32'hBEEF);
    check("vld_pulse", 32'(mdr_valid_o), 32'h1);
    step();
    check("vld_drop", 32'(mdr_valid_o), 32'h0);
    check("idle_busy", 32'(busy_o), 32'h0);

    // overrun
    mar_ld_ni = 0; addr_src_i = 2'b01; alu_result_i = 16'h1111; step();
    alu_result_i = 16'h2222; step(); idle_inputs();
    check("ovr_mar", 32'(mem_addr_o), 32'h1111);
    check("ovr_set", 32'(overrun_o), 32'h1);
    mem_ack_i = 1; mem_data_i = 16'h5555; step(); idle_inputs();
    mar_ld_ni = 0; alu_result_i = 16'h3333; step(); idle_inputs();
    mem_ack_i = 1; step(); idle_inputs();
    check("ovr_sticky", 32'(overrun_o), 32'h1);

    // abort with simultaneous ack
    mar_ld_ni = 0; alu_result_i = 16'h4444; step(); idle_inputs();
    mdr_keep = mdr_o;
    mar_rst_ni = 0; mem_ack_i = 1; mem_data_i = 16'hDEAD; step(); idle_inputs();
    check("abort_mar", 32'(mem_addr_o), 32'h0);
    check("abort_mdr", 32'(mdr_o), 32'(mdr_keep));
    check("abort_vld", 32'(mdr_valid_o), 32'h0);
    check("abort_busy", 32'(busy_o), 32'h0);
    check("ovr_hold", 32'(overrun_o), 32'h1);
    do_reset();
    check("ovr_clear", 32'(overrun_o), 32'h0);

    // back-to-back reads
    mar_ld_ni = 0; addr_src_i = 2'b00; step(); idle_inputs();
    mem_ack_i = 1; mem_data_i = 16'hA5A5; step(); idle_inputs();
    check("b2b_done", 32'(mdr_valid_o), 32'h1);
    mar_ld_ni = 0; addr_src_i = 2'b10; data_addr_i = 16'h0040; step(); idle_inputs();
    check("b2b_rd", 32'(mem_rd_o), 32'h1);
    check("b2b_addr", 32'(mem_addr_o), 32'h0040);

    // random strobes against the model
    for (int i = 0; i < 600; i++) begin
      reset_i       = ($urandom_range(0, 99) == 0);
      pc_rst_ni     = ($urandom_range(0, 15) != 0);
      pc_ld_ni      = $urandom_range(0, 1) == 1;
      mar_rst_ni    = ($urandom_range(0, 15) != 0);
      mar_ld_ni     = ($urandom_range(0, 2) != 0);
      mem_ack_i     = ($urandom_range(0, 2) == 0);
      pc_src_i      = 3'($urandom_range(0, 7));
      addr_src_i    = 2'($urandom_range(0, 3));
      branch_addr_i = 16'($urandom);
      alu_result_i  = 16'($urandom);
      data_addr_i   = 16'($urandom);
      mem_data_i    = 16'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_mar_datapath.md
# pc_mar_datapath

Datapath responder for the sequencer's PC/MAR control strobes. It holds the program counter (PC), memory address register (MAR) and memory data register (MDR), and resolves the PC and address source muxes. It also runs the single-outstanding memory read that every MAR load triggers. It sits between the control matrix, which drives the active-low strobes and selectors, and the memory port.

## Interface
Parameters:
- `ADDR_WIDTH`, 16: PC/MAR width.
- `DATA_WIDTH`, 16: MDR and memory data width.
- `PC_SELECT_SIZE`, 3: PC mux selector width (Mux8).
- `ADDR_SELECT_SIZE`, 2: address mux selector width (Mux4).
- `RESET_VECTOR`, 16'hFFFE: constant loaded via `pc_src_i`=3'b010.

Ports:
- `clk_i`, in, 1: clock. All state updates on the rising edge.
- `reset_i`, in, 1: synchronous, active-high reset.
- `pc_rst_ni`, in, 1: active-low. PC <= 0.
- `pc_ld_ni`, in, 1: active-low. PC <= PC mux output.
- `pc_src_i`, in, PC_SELECT_SIZE: PC mux select.
- `mar_rst_ni`, in, 1: active-low. MAR <= 0 and the read is aborted.
- `mar_ld_ni`, in, 1: active-low. MAR <= address mux output and a read starts.
- `addr_src_i`, in, ADDR_SELECT_SIZE: address mux select.
- `branch_addr_i`, in, ADDR_WIDTH: branch target.
- `alu_result_i`, in, ADDR_WIDTH: ALU result.
- `data_addr_i`, in, ADDR_WIDTH: operand address.
- `mem_rd_o`, out, 1: read request.
- `mem_addr_o`, out, ADDR_WIDTH: equals MAR.
- `mem_ack_i`, in, 1: read data valid.
- `mem_data_i`, in, DATA_WIDTH: read data.
- `pc_o`, out, ADDR_WIDTH: PC.
- `mdr_o`, out, DATA_WIDTH: MDR.
- `mdr_valid_o`, out, 1: one-cycle pulse when the MDR is updated.
- `busy_o`, out, 1: read outstanding.
- `overrun_o`, out, 1: sticky. MAR load rejected while busy.

## Operation
PC mux (`pc_src_i`):
- 000: PC+1, mod 2^ADDR_WIDTH, so 16'hFFFF -> 16'h0000.
- 001: `branch_addr_i`.
- 010: RESET_VECTOR.
- 011: `alu_result_i`.
- 100–111: PC (hold).

Address mux (`addr_src_i`):
- 00: PC.
- 01: `alu_result_i`.
- 10: `data_addr_i`.
- 11: 0.
- The address mux uses the current (pre-edge) PC.

Register priority, per register, highest first: `reset_i` > rst strobe > ld strobe > hold.

Read FSM, states IDLE, REQ, DONE:
- IDLE: a MAR load is accepted -> REQ.
- REQ: `mem_rd_o`=1 and `busy_o`=1. When `mem_ack_i`=1 at an edge, MDR <= `mem_data_i` -> DONE. Otherwise stay in REQ; there is no timeout.
- DONE: `mdr_valid_o`=1. An accepted MAR load -> REQ; otherwise -> IDLE.
- `mar_rst_ni`=0 in any state -> IDLE. MAR is set to 0 and MDR is held. This also covers an ack in the same cycle: it is discarded.
- MAR load while in REQ: ignored. MAR is held and `overrun_o` is set; it clears only on `reset_i`.
- `mar_rst_ni` and `mar_ld_ni` both low: the reset wins, no read starts, and no overrun is flagged.

## Timing
- Reset values: PC=0, MAR=0, MDR=0, state IDLE. `mem_rd_o`=0, `mdr_valid_o`=0, `busy_o`=0, `overrun_o`=0.
- All outputs are registered or decoded from state. There is no combinational path from the inputs to the outputs.
- MAR load at edge N: `mem_addr_o` is valid and `mem_rd_o`=1 from edge N.
- Ack sampled at edge M: MDR is valid and `mdr_valid_o`=1 for the cycle after M, and `mem_rd_o` is deasserted at M.
- Minimum load-to-data latency is 2 edges (ack on the first REQ cycle). Back-to-back reads are issued by loading the MAR in DONE.
- A PC load and a MAR load at the same edge: the MAR takes the old PC.

## Test plan
- Vector sequence. Drive `reset_i` 1 cycle. Then cycle 1: `pc_rst_ni`=0 and `mar_rst_ni`=0. Cycle 2: `pc_ld_ni`=0, `pc_src_i`=010. Cycle 3: `mar_ld_ni`=0, `addr_src_i`=00. Required: `pc_o`=FFFE after cycle 2, `mem_addr_o`=FFFE and `mem_rd_o`=1 after cycle 3.
- Increment wrap. Load PC=FFFF via the branch source, then `pc_src_i`=000 with a load. Required: `pc_o`=0000.
- Read with wait states. Load MAR=0x1234 and hold `mem_ack_i` low for 3 cycles, then ack with data 0xBEEF. Required: `busy_o` high for 4 cycles, then `mdr_o`=BEEF, a single `mdr_valid_o` pulse, and the FSM back in IDLE.
- Overrun. Load the MAR while in REQ. Required: MAR unchanged, `overrun_o`=1 and it stays set through later reads until `reset_i`.
- Abort. Assert `mar_rst_ni`=0 in the same cycle as `mem_ack_i`=1. Required: MAR=0, MDR unchanged, no `mdr_valid_o`, `busy_o`=0.
- Back-to-back. Load the MAR in the DONE cycle with `addr_src_i`=10 and `data_addr_i`=0x0040. Required: `mem_rd_o` reasserts the next cycle with `mem_addr_o`=0040.
